drum_hit_detector: RTL
======================

// Module: drum_hit_detector
// PURPOSE
//  Consumes the 12-bit low-pass output of the 31-tap FIR stage and turns piezo energy into drum strikes.
//  Rectifies each new sample, arms on a threshold crossing, tracks the peak over a fixed window,
//  then emits a one-cycle hit pulse with a 7-bit velocity. Enforces a re-trigger holdoff.
//  Sits directly downstream of the FIR, one instance per sensor channel; feeds the sound/voice trigger logic.
// PARAMETERS
//  THRESH_ON   200  magnitude (0..2047) at or above which IDLE arms
//  THRESH_OFF  100  magnitude below which HOLDOFF may release (requires THRESH_OFF <= THRESH_ON)
//  PEAK_WIN     96  accepted samples tracked for the peak (2 ms at 48 kHz), 1..1023
//  HOLDOFF     480  minimum accepted samples after a hit before re-arm (10 ms), 1..4095
// PORTS
//  clock     in   1   system clock
//  reset     in   1   synchronous, active-high
//  fir_y     in  12   signed filtered sample (FIR y)
//  fir_done  in   1   FIR done level; stays high until the next FIR start
//  hit       out  1   one-cycle strike pulse
//  velocity  out  7   peak[10:4] of the strike; held until the next hit
//  busy      out  1   high in ATTACK or HOLDOFF
// BEHAVIOUR
//  - Clock is clock. Reset is synchronous and active-high.
//  - Reset values: hit=0, velocity=0, busy=0, state=IDLE, all counters and peak =0, mag_v=0, done_q=1.
//  - Because done_q resets to 1, a fir_done already high at reset release is NOT accepted.
//  - Accept: fir_done is a level. A sample is accepted only on the cycle where fir_done=1 and done_q=0.
//    done_q <= fir_done every cycle. One accept per FIR output, however long done stays high.
//  - Stage 1 (the accept cycle):
//    - mag <= |fir_y| as 11-bit unsigned; -2048 saturates to 2047.
//    - mag_v <= 1 for exactly one cycle.
//  - Stage 2: the FSM acts only on cycles where mag_v=1. Counters count accepted samples, not clocks.
//  - IDLE: if mag >= THRESH_ON -> ATTACK.
//    - On this transition: peak=mag, win_cnt=1.
//  - ATTACK: on each sample, peak=max(peak,mag) and win_cnt++. Dropping below threshold does NOT abort.
//    - When the sample brings win_cnt to PEAK_WIN -> HOLDOFF. In the same cycle:
//      - hit<=1 (asserted for the next cycle only);
//      - velocity<=max(peak,mag)[10:4];
//      - ho_cnt=0.
//    - PEAK_WIN=1: the arming sample itself completes the window. IDLE -> HOLDOFF with a hit.
//  - HOLDOFF: ho_cnt++ per sample, saturating at HOLDOFF. Samples >= THRESH_ON are ignored (no re-trigger).
//    - Exit to IDLE only on a sample where ho_cnt has already reached HOLDOFF AND mag < THRESH_OFF.
//    - Otherwise stay in HOLDOFF indefinitely (sustained ring keeps it locked out).
//  - Latency: hit is high in cycle N+2, where N is the accept cycle of the last window sample.
//  - Width rules:
//    - peak: 11b unsigned.
//    - win_cnt: 10b.
//    - ho_cnt: 12b.
//    - Compares are unsigned on 11b magnitudes.
//  - Reset in any state or mid-window: returns to reset values the next cycle. No hit is emitted for a
//    partial window.
//  - busy = (state != IDLE), registered.
// STRUCTURE
//  - Shared constants header drum_defs.vh: state encodings (IDLE=2'd0, ATTACK=2'd1, HOLDOFF=2'd2),
//    MAG_W=11, VEL_W=7, default thresholds. Shared with the voice-trigger block.
//  - Sub-module sample_magnitude: registered abs with saturation, plus the done edge detect
//    (outputs mag and mag_v).
//  - Top: FSM, peak register, counters.
// TESTING
//  1. Reset with fir_done held high, release, keep fir_done high 40 cycles
//     -> no accept, no hit, busy=0.
//  2. PEAK_WIN=4. Drive samples 50, 300, -900, 600, 100, each with a 0->1 done edge and >=32 clocks apart:
//     - arms on 300;
//     - hit after the 4th window sample (100), cycle N+2;
//     - velocity=900>>4=56.
//  3. Sample -2048 in window -> velocity=127. Sample +2047 -> velocity=127.
//  4. HOLDOFF=8, samples of 400 continuing after the hit -> no second hit.
//     - Then samples of 50 -> IDLE exactly on the first <100 sample once ho_cnt=8.
//     - Next sample of 250 re-arms.
//  5. Assert reset for one cycle during ATTACK after 2 of 4 window samples
//     -> no hit; velocity=0; busy=0.
//     - A following window produces a normal hit.
//  6. fir_done pulses that each last 1 cycle vs. 20 cycles -> identical accept count and identical hit/velocity.

Source files
------------

// File: rtl/drum_hit_detector_pkg.sv
// Shared constants, state encoding and magnitude helpers for the drum hit detector
// and the voice-trigger logic that consumes its strikes.
package drum_hit_detector_pkg;

    localparam int Y_W   = 12;
    localparam int MAG_W = 11;
    localparam int VEL_W = 7;
    localparam int WIN_W = 10;
    localparam int HO_W  = 12;

    localparam int DEF_THRESH_ON  = 200;
    localparam int DEF_THRESH_OFF = 100;
    localparam int DEF_PEAK_WIN   = 96;
    localparam int DEF_HOLDOFF    = 480;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    // Two's-complement magnitude; the single unrepresentable case (-2048) clamps to full scale.
    function automatic logic [MAG_W-1:0] abs_sat(input logic signed [Y_W-1:0] y);
        logic [Y_W-1:0] neg;
        neg = '0;
        if (!y[Y_W-1]) begin
            return y[MAG_W-1:0];
        end
        if (y == {1'b1, {(Y_W-1){1'b0}}}) begin
            return '1;
        end
        neg = -y;
        return neg[MAG_W-1:0];
    endfunction

    function automatic logic [MAG_W-1:0] max_mag(input logic [MAG_W-1:0] a,
                                                 input logic [MAG_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/drum_hit_detector_sample_magnitude.sv
// Front end of the detector: turns each new FIR result (rising edge of the done level)
// into one registered magnitude with a single-cycle valid.
module sample_magnitude
    import drum_hit_detector_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [Y_W-1:0]   fir_y_i,
    input  logic                    fir_done_i,
    output logic [MAG_W-1:0]        mag_o,
    output logic                    mag_v_o
);

    logic             done_q;
    logic [MAG_W-1:0] mag_q;
    logic             mag_v_q;
    logic             accept;

    assign accept = fir_done_i & ~done_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // Starting high means a done level already asserted at reset release is treated as stale.
            done_q  <= 1'b1;
            mag_q   <= '0;
            mag_v_q <= 1'b0;
        end else begin
            done_q  <= fir_done_i;
            mag_v_q <= accept;
            if (accept) begin
                mag_q <= abs_sat(fir_y_i);
            end
        end
    end

    assign mag_o   = mag_q;
    assign mag_v_o = mag_v_q;

endmodule

// File: rtl/drum_hit_detector.sv
// Per-channel strike detector: arms on a threshold crossing, tracks the window peak,
// emits a one-cycle hit with velocity, then locks out re-triggers for a holdoff period.
module drum_hit_detector
    import drum_hit_detector_pkg::*;
#(
    parameter int THRESH_ON  = DEF_THRESH_ON,
    parameter int THRESH_OFF = DEF_THRESH_OFF,
    parameter int PEAK_WIN   = DEF_PEAK_WIN,
    parameter int HOLDOFF    = DEF_HOLDOFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [Y_W-1:0]   fir_y,
    input  logic                    fir_done,
    output logic                    hit,
    output logic [VEL_W-1:0]        velocity,
    output logic                    busy
);

    localparam logic [MAG_W-1:0] ON_M    = MAG_W'(THRESH_ON);
    localparam logic [MAG_W-1:0] OFF_M   = MAG_W'(THRESH_OFF);
    localparam logic [WIN_W-1:0] WIN_END = WIN_W'(PEAK_WIN);
    localparam logic [HO_W-1:0]  HO_END  = HO_W'(HOLDOFF);

    logic [MAG_W-1:0] mag;
    logic             mag_v;

    state_e           state_q, state_d;
    logic [MAG_W-1:0] peak_q, peak_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;
    logic             hit_q, hit_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic             busy_q;
    logic [MAG_W-1:0] new_peak;
    logic [WIN_W-1:0] win_inc;

    sample_magnitude u_mag (
        .clock      (clock),
        .reset      (reset),
        .fir_y_i    (fir_y),
        .fir_done_i (fir_done),
        .mag_o      (mag),
        .mag_v_o    (mag_v)
    );

    assign new_peak = max_mag(peak_q, mag);
    assign win_inc  = win_cnt_q + WIN_W'(1);

    // NOTE: every always_comb output is defaulted first so no path leaves a value unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        peak_d    = peak_q;
        win_cnt_d = win_cnt_q;
        ho_cnt_d  = ho_cnt_q;
        vel_d     = vel_q;
        hit_d     = 1'b0;

        if (mag_v) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mag >= ON_M) begin
                        peak_d    = mag;
                        win_cnt_d = WIN_W'(1);
                        if (WIN_END == WIN_W'(1)) begin
                            state_d  = ST_HOLDOFF;
                            hit_d    = 1'b1;
                            vel_d    = mag[MAG_W-1 -: VEL_W];
                            ho_cnt_d = '0;
                        end else begin
                            state_d = ST_ATTACK;
                        end
                    end
                end
                ST_ATTACK: begin
                    // Sub-threshold samples still count toward the window; only the count ends it.
                    peak_d    = new_peak;
                    win_cnt_d = win_inc;
                    if (win_inc == WIN_END) begin
                        state_d  = ST_HOLDOFF;
                        hit_d    = 1'b1;
                        vel_d    = new_peak[MAG_W-1 -: VEL_W];
                        ho_cnt_d = '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (ho_cnt_q == HO_END && mag < OFF_M) begin
                        state_d = ST_IDLE;
                    end else if (ho_cnt_q != HO_END) begin
                        ho_cnt_d = ho_cnt_q + HO_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            peak_q    <= '0;
            win_cnt_q <= '0;
            ho_cnt_q  <= '0;
            hit_q     <= 1'b0;
            vel_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            peak_q    <= peak_d;
            win_cnt_q <= win_cnt_d;
            ho_cnt_q  <= ho_cnt_d;
            hit_q     <= hit_d;
            vel_q     <= vel_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign hit      = hit_q;
    assign velocity = vel_q;
    assign busy     = busy_q;

endmodule
